// File: rtl/key_cmd_pkg.sv
// Shared key codes, move encodings and step-generator state type for the
// keyboard command block.
package key_cmd_pkg;

   localparam int CODE_W = 9;
   localparam int CNT_W  = 25;

   localparam logic [CODE_W-1:0] KEY_A      = 9'h01C;
   localparam logic [CODE_W-1:0] KEY_D      = 9'h023;
   localparam logic [CODE_W-1:0] KEY_ENTER  = 9'h05A;
   localparam logic [CODE_W-1:0] KEY_RENTER = 9'h15A;
   localparam logic [CODE_W-1:0] KEY_P      = 9'h04D;

   localparam logic [1:0] MOVE_NONE  = 2'b00;
   localparam logic [1:0] MOVE_LEFT  = 2'b10;
   localparam logic [1:0] MOVE_RIGHT = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } step_state_e;

   // Main and keypad Enter share one held flag.
   function automatic logic is_enter(input logic [CODE_W-1:0] code);
      return (code == KEY_ENTER) || (code == KEY_RENTER);
   endfunction

endpackage

// File: rtl/key_cmd_if.sv
// Keyboard-decoder inputs and game-command outputs of key_cmd.
interface key_cmd_if;
   import key_cmd_pkg::*;

   logic              key_valid;
   logic [CODE_W-1:0] last_change;
   logic [511:0]      key_down;
   logic              in_game;
   logic [1:0]        move;
   logic              step;
   logic              start;
   logic              pause;

   modport master (
      output key_valid, last_change, key_down, in_game,
      input  move, step, start, pause
   );

   modport slave (
      input  key_valid, last_change, key_down, in_game,
      output move, step, start, pause
   );

endinterface

// File: rtl/key_cmd_repeat.sv
// Step pulse generator: immediate step on a new nonzero direction, then
// auto-repeat after REPEAT_DELAY and every REPEAT_PERIOD cycles.
module key_repeat
   import key_cmd_pkg::*;
#(
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] move,
   output logic       step
);

   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

   step_state_e      state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [1:0]       move_r;
   logic             step_r;

   // move is the next-cycle value of the owner's move register, so step_r
   // lands in the same cycle as the visible move change.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         move_r  <= MOVE_NONE;
         step_r  <= 1'b0;
      end else begin
         move_r <= move;
         if (move != move_r) begin
            cnt_r <= CNT_ZERO;
            if (move != MOVE_NONE) begin
               state_r <= ST_DELAY;
               step_r  <= 1'b1;
            end else begin
               state_r <= ST_IDLE;
               step_r  <= 1'b0;
            end
         end else begin
            case (state_r)
               ST_DELAY: begin
                  if (cnt_r == DELAY_LAST) begin
                     state_r <= ST_REPEAT;
                     cnt_r   <= CNT_ZERO;
                     step_r  <= 1'b1;
                  end else begin
                     state_r <= ST_DELAY;
                     cnt_r   <= cnt_r + CNT_ONE;
                     step_r  <= 1'b0;
                  end
               end
               ST_REPEAT: begin
                  if (cnt_r == PERIOD_LAST) begin
                     cnt_r  <= CNT_ZERO;
                     step_r <= 1'b1;
                  end else begin
                     cnt_r  <= cnt_r + CNT_ONE;
                     step_r <= 1'b0;
                  end
                  state_r <= ST_REPEAT;
               end
               default: begin
                  state_r <= ST_IDLE;
                  cnt_r   <= CNT_ZERO;
                  step_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   // A pulse already registered is masked during the reset cycle itself.
   assign step = step_r & ~rst;

endmodule

// File: rtl/key_cmd.sv
// Keyboard command decoder: held-key tracking, last-pressed-wins direction,
// start pulse, pause toggle, and the step generator.
module key_cmd
   import key_cmd_pkg::*;
#(
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000
) (
   input  logic     clk,
   input  logic     rst,
   key_cmd_if.slave kb
);

   logic       press_s, release_s;
   logic       is_a_s, is_d_s, is_enter_s, is_p_s;
   logic       held_a_r, held_d_r, held_enter_r, held_p_r;
   logic       held_a_s, held_d_s, held_enter_s, held_p_s;
   logic [1:0] dir_r, dir_s;
   logic [1:0] move_r, move_s;
   logic       pause_r, pause_s;
   logic       start_r, start_s;
   logic       step_s;

   // Event decode and next-state for flags, direction, pause, start and move.
   always_comb begin
      press_s    = kb.key_valid &  kb.key_down[kb.last_change];
      release_s  = kb.key_valid & ~kb.key_down[kb.last_change];
      is_a_s     = (kb.last_change == KEY_A);
      is_d_s     = (kb.last_change == KEY_D);
      is_enter_s = is_enter(kb.last_change);
      is_p_s     = (kb.last_change == KEY_P);

      held_a_s     = held_a_r;
      held_d_s     = held_d_r;
      held_enter_s = held_enter_r;
      held_p_s     = held_p_r;
      if (press_s) begin
         held_a_s     = held_a_r     | is_a_s;
         held_d_s     = held_d_r     | is_d_s;
         held_enter_s = held_enter_r | is_enter_s;
         held_p_s     = held_p_r     | is_p_s;
      end else if (release_s) begin
         held_a_s     = held_a_r     & ~is_a_s;
         held_d_s     = held_d_r     & ~is_d_s;
         held_enter_s = held_enter_r & ~is_enter_s;
         held_p_s     = held_p_r     & ~is_p_s;
      end else begin
         held_a_s     = held_a_r;
         held_d_s     = held_d_r;
         held_enter_s = held_enter_r;
         held_p_s     = held_p_r;
      end

      // Typematic makes of an already-held key must not steal direction.
      dir_s = dir_r;
      if (press_s && is_a_s && !held_a_r) begin
         dir_s = MOVE_LEFT;
      end else if (press_s && is_d_s && !held_d_r) begin
         dir_s = MOVE_RIGHT;
      end else if (release_s && is_a_s && (dir_r == MOVE_LEFT)) begin
         dir_s = held_d_r ? MOVE_RIGHT : MOVE_NONE;
      end else if (release_s && is_d_s && (dir_r == MOVE_RIGHT)) begin
         dir_s = held_a_r ? MOVE_LEFT : MOVE_NONE;
      end else begin
         dir_s = dir_r;
      end

      pause_s = pause_r;
      if (!kb.in_game) begin
         pause_s = 1'b0;
      end else if (press_s && is_p_s && !held_p_r) begin
         pause_s = ~pause_r;
      end else begin
         pause_s = pause_r;
      end

      start_s = press_s & is_enter_s & ~held_enter_r & ~kb.in_game;

      move_s = MOVE_NONE;
      if (kb.in_game && !pause_s) begin
         move_s = dir_s;
      end else begin
         move_s = MOVE_NONE;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         held_a_r     <= 1'b0;
         held_d_r     <= 1'b0;
         held_enter_r <= 1'b0;
         held_p_r     <= 1'b0;
         dir_r        <= MOVE_NONE;
         move_r       <= MOVE_NONE;
         pause_r      <= 1'b0;
         start_r      <= 1'b0;
      end else begin
         held_a_r     <= held_a_s;
         held_d_r     <= held_d_s;
         held_enter_r <= held_enter_s;
         held_p_r     <= held_p_s;
         dir_r        <= dir_s;
         move_r       <= move_s;
         pause_r      <= pause_s;
         start_r      <= start_s;
      end
   end

   key_repeat #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_repeat (
      .clk  (clk),
      .rst  (rst),
      .move (move_s),
      .step (step_s)
   );

   assign kb.move  = move_r;
   assign kb.step  = step_s;
   assign kb.start = start_r;
   assign kb.pause = pause_r;

endmodule

// File: tb/tb_key_cmd.sv
// Directed, table-driven bench for key_cmd with short repeat timing.
module tb_key_cmd;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   key_cmd_if kb ();

   key_cmd #(
      .REPEAT_DELAY  (8),
      .REPEAT_PERIOD (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kb  (kb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic       valid;
      logic [8:0] code;
      logic       down;
      logic       ig;
      logic [1:0] move;
      logic       step;
      logic       start;
      logic       pause;
   } vec_t;

   vec_t tbl [0:29];

   task automatic check(input string nm, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0b expected=%0b", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      kb.key_valid = 1'b0;
   endtask

   task automatic key_event(input logic [8:0] code, input logic down);
      kb.key_down[code] = down;
      kb.last_change    = code;
      kb.key_valid      = 1'b1;
   endtask

   task automatic check_all(input string nm, input logic [1:0] mv, input logic st,
                            input logic sr, input logic pz);
      check({nm, "_move"},  kb.move,         mv);
      check({nm, "_step"},  {1'b0, kb.step},  {1'b0, st});
      check({nm, "_start"}, {1'b0, kb.start}, {1'b0, sr});
      check({nm, "_pause"}, {1'b0, kb.pause}, {1'b0, pz});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      kb.key_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst             = 1'b1;
      kb.key_valid    = 1'b0;
      kb.last_change  = 9'h000;
      kb.key_down     = '0;
      kb.in_game      = 1'b0;

      //                rst   vld   code    down  ig    move   stp   srt   pz
      tbl[0]  = '{1'b1, 1'b1, 9'h05A, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 9'h05A, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 9'h05A, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 9'h15A, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 9'h05A, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 9'h05A, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 9'h15A, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 9'h15A, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 9'h01C, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 9'h023, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 9'h023, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 9'h01C, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 9'h023, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 1'b1, 9'h01C, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{1'b0, 1'b1, 9'h04D, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1};
      tbl[16] = '{1'b0, 1'b1, 9'h04D, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1};
      tbl[17] = '{1'b0, 1'b1, 9'h04D, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1};
      tbl[18] = '{1'b0, 1'b1, 9'h01C, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1};
      tbl[19] = '{1'b0, 1'b1, 9'h04D, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0};
      tbl[20] = '{1'b0, 1'b1, 9'h04D, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0};
      tbl[21] = '{1'b0, 1'b1, 9'h04D, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1};
      tbl[22] = '{1'b0, 1'b1, 9'h04D, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1};
      tbl[23] = '{1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[24] = '{1'b0, 1'b1, 9'h04D, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[25] = '{1'b0, 1'b1, 9'h04D, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[26] = '{1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0};
      tbl[27] = '{1'b0, 1'b1, 9'h05A, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0};
      tbl[28] = '{1'b0, 1'b1, 9'h05A, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0};
      tbl[29] = '{1'b0, 1'b1, 9'h01C, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};

      do_reset();
      check_all("reset", 2'b00, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 30; i++) begin
         rst        = tbl[i].rst;
         kb.in_game = tbl[i].ig;
         if (tbl[i].valid) begin
            key_event(tbl[i].code, tbl[i].down);
         end
         tick();
         rst = 1'b0;
         check_all($sformatf("vec%0d", i), tbl[i].move, tbl[i].step,
                   tbl[i].start, tbl[i].pause);
      end

      // Auto-repeat timing, then in_game drop coinciding with a P press.
      do_reset();
      kb.in_game = 1'b1;
      key_event(9'h01C, 1'b1);
      tick();
      for (int c = 1; c <= 20; c++) begin
         check($sformatf("rep_c%0d_move", c), kb.move, 2'b10);
         check($sformatf("rep_c%0d_step", c), {1'b0, kb.step},
               {1'b0, (c == 1 || c == 9 || c == 13 || c == 17)});
         if (c < 20) tick();
      end
      kb.in_game = 1'b0;
      key_event(9'h04D, 1'b1);
      tick();
      check_all("drop_p", 2'b00, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("drop_quiet%0d_step", c), {1'b0, kb.step}, 2'b00);
      end
      key_event(9'h04D, 1'b0);
      tick();
      key_event(9'h01C, 1'b0);
      tick();

      // Reset in the cycle a repeat step is visible.
      do_reset();
      kb.in_game = 1'b1;
      key_event(9'h01C, 1'b1);
      tick();
      for (int c = 0; c < 8; c++) tick();
      check("rst_pre_step", {1'b0, kb.step}, 2'b01);
      rst = 1'b1;
      #1;
      check("rst_same_cycle_step", {1'b0, kb.step}, 2'b00);
      tick();
      rst = 1'b0;
      check_all("rst_after", 2'b00, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 12; c++) begin
         tick();
         check($sformatf("rst_idle%0d_move", c), kb.move, 2'b00);
         check($sformatf("rst_idle%0d_step", c), {1'b0, kb.step}, 2'b00);
      end
      key_event(9'h01C, 1'b1);
      tick();
      check_all("rst_repress", 2'b10, 1'b1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/key_cmd.md
KEY_CMD -- requirements
Module: key_cmd

Interface
REQ-001 Parameter REPEAT_DELAY, 25_000_000, clk cycles from first step pulse to first auto-repeat step pulse; legal range 2 to 2^25-1.
REQ-002 Parameter REPEAT_PERIOD, 5_000_000, clk cycles between auto-repeat step pulses; legal range 2 to 2^25-1.
REQ-003 clk  input  1  system clock, 100 MHz.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 key_valid  input  1  one-cycle strobe from the keyboard decoder: last_change and key_down are updated.
REQ-006 last_change  input  9  scan code of the most recent make or break event.
REQ-007 key_down  input  512  per-scan-code held level from the keyboard decoder.
REQ-008 in_game  input  1  1 = game state, 0 = cover screen.
REQ-009 move  output  2  registered held direction: 2'b10 left, 2'b01 right, 2'b00 none.
REQ-010 step  output  1  one-cycle movement pulse: on the initial press, then auto-repeat.
REQ-011 start  output  1  one-cycle game-start pulse.
REQ-012 pause  output  1  registered pause level.

Function
REQ-013 Press event SHALL be key_valid && key_down[last_change]; release event SHALL be key_valid && !key_down[last_change].
REQ-014 Held flags for A (9'h01C), D (9'h023), Enter (9'h05A or 9'h15A) and P (9'h04D) SHALL be set on press events and cleared on release events.
REQ-015 Direction priority SHALL be last-pressed-wins: with A and D both held, move follows the most recent press; releasing the winner SHALL hand move to the still-held key.
REQ-016 move SHALL be 2'b00 whenever in_game=0 or pause=1; otherwise move SHALL reflect REQ-015.
REQ-017 move SHALL update exactly one cycle after the key_valid event that changes it.
REQ-018 The step generator SHALL have states IDLE, DELAY and REPEAT, driven by a 25-bit counter.
REQ-019 Move change to a nonzero value from any state SHALL assert step in the same cycle move updates, clear the counter and enter DELAY.
REQ-020 In DELAY, step SHALL pulse when the counter reaches REPEAT_DELAY-1; the block SHALL then enter REPEAT with the counter cleared.
REQ-021 In REPEAT, step SHALL pulse every REPEAT_PERIOD cycles.
REQ-022 Move change to 2'b00 from any state SHALL enter IDLE, clear the counter and emit no step.
REQ-023 Typematic make repeats of an already-held key SHALL NOT alter move, restart the step generator, or emit start or pause toggles.
REQ-024 start SHALL pulse for exactly one cycle, one cycle after an Enter press event, but only when the Enter held flag was 0 and in_game=0.
REQ-025 pause SHALL toggle one cycle after a P press event, but only when the P held flag was 0 and in_game=1.
REQ-026 pause SHALL be forced to 0 on any cycle where in_game=0; this SHALL take precedence over a simultaneous P press.
REQ-027 When in_game falls, move SHALL go to 2'b00 and the step generator SHALL go to IDLE on the next cycle, without emitting a step.
REQ-028 Held flags SHALL keep tracking regardless of in_game and pause, so a key still held when play resumes is honoured without a re-press.

Reset
REQ-029 On rst: move=2'b00, step=0, start=0, pause=0, all held flags 0, last direction = none, step state IDLE, counter 0.
REQ-030 rst asserted mid-repeat SHALL suppress any step pulse in that cycle.
REQ-031 Events arriving on the cycle rst is asserted SHALL be discarded.

Structure
REQ-032 Package key_cmd_pkg SHALL hold the key-code constants (KEY_A, KEY_D, KEY_ENTER, KEY_RENTER, KEY_P), the move encodings and the step-state enum.
REQ-033 The step generator (REQ-018 to REQ-022) SHALL be a single sub-module, key_repeat, with inputs clk, rst, move and outputs step.
REQ-034 key_cmd SHALL contain the event decoding, held flags, priority logic, start and pause.

Verification (REPEAT_DELAY=8, REPEAT_PERIOD=4)
REQ-035 in_game=1, A press at cycle 0, held -> move=10 from cycle 1; step at cycles 1, 9, 13, 17.
REQ-036 A held, D pressed, then D released -> move 10 -> 01 -> 10, with step immediately on each change and DELAY restarted each time.
REQ-037 in_game=0, Enter press followed by three typematic Enter makes -> exactly one start pulse; move stays 00.
REQ-038 in_game=1, P press/release twice -> pause 1 then 0; move=00 and no step while paused, A still held honoured after unpause.
REQ-039 A held in REPEAT, in_game drops on the same cycle as a P press -> pause=0, move=00, no step.
REQ-040 rst pulsed mid-REPEAT with A held -> all outputs 0; no step in the reset cycle; after release, move stays 00 until a fresh A press event.
